// File: rtl/fc_12_pkg.sv
// Shared BNN fully-connected constants and the binary-signed multiply helper.
package fc_12_pkg;

    localparam int N_LANES = 12;
    localparam int N_BEATS = 16;
    localparam int N_W     = N_LANES * N_BEATS;
    localparam int DW      = 32;
    localparam int CNT_W   = $clog2(N_BEATS);

    // A weight bit of 1 passes x through; a weight bit of 0 negates it (wrap-around).
    function automatic logic signed [DW-1:0] bin_mul(input logic sel, input logic signed [DW-1:0] x);
        return sel ? x : -x;
    endfunction

endpackage

// File: rtl/fc_lane_sum.sv
// Combinational signed partial sum of one beat: 12 lanes, each multiplied by +1 or -1.
module fc_lane_sum
    import fc_12_pkg::*;
(
    input  logic signed [DW-1:0]      i_din [N_LANES],
    input  logic        [N_LANES-1:0] i_w,
    output logic signed [DW-1:0]      o_partial
);

    always_comb begin
        // NOTE: blocking assignments in combinational logic; the running sum must update within the loop.
        o_partial = '0;
        for (int j = 0; j < N_LANES; j++) begin
            o_partial = o_partial + bin_mul(i_w[j], i_din[j]);
        end
    end

endmodule

// File: rtl/fc_12.sv
// Binary-weight fully-connected neuron: serial weight load, 16-beat x 12-lane signed dot product.
module fc_12
    import fc_12_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 ivalid,
    input  logic signed [DW-1:0] din_0,
    input  logic signed [DW-1:0] din_1,
    input  logic signed [DW-1:0] din_2,
    input  logic signed [DW-1:0] din_3,
    input  logic signed [DW-1:0] din_4,
    input  logic signed [DW-1:0] din_5,
    input  logic signed [DW-1:0] din_6,
    input  logic signed [DW-1:0] din_7,
    input  logic signed [DW-1:0] din_8,
    input  logic signed [DW-1:0] din_9,
    input  logic signed [DW-1:0] din_10,
    input  logic signed [DW-1:0] din_11,
    input  logic                 weight,
    input  logic                 weight_en,
    output logic                 ovalid,
    output logic signed [DW-1:0] dout
);

    logic        [N_W-1:0]     r_w;
    logic        [CNT_W-1:0]   r_cnt;
    logic signed [DW-1:0]      r_acc;
    logic signed [DW-1:0]      r_dout;
    logic                      r_ovalid;

    logic signed [DW-1:0]      w_din [N_LANES];
    logic        [N_LANES-1:0] w_slice;
    logic signed [DW-1:0]      w_partial;
    logic signed [DW-1:0]      w_sum;

    assign w_din[0]  = din_0;
    assign w_din[1]  = din_1;
    assign w_din[2]  = din_2;
    assign w_din[3]  = din_3;
    assign w_din[4]  = din_4;
    assign w_din[5]  = din_5;
    assign w_din[6]  = din_6;
    assign w_din[7]  = din_7;
    assign w_din[8]  = din_8;
    assign w_din[9]  = din_9;
    assign w_din[10] = din_10;
    assign w_din[11] = din_11;

    // Beat k uses weights k*12 .. k*12+11.
    assign w_slice = r_w[int'(r_cnt) * N_LANES +: N_LANES];
    assign w_sum   = r_acc + w_partial;

    fc_lane_sum u_lane_sum (
        .i_din     (w_din),
        .i_w       (w_slice),
        .o_partial (w_partial)
    );

    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: the weight register is a flop array, not a RAM, so it takes the async reset like everything else.
        if (!rstn) begin
            r_w      <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_dout   <= '0;
            r_ovalid <= 1'b0;
        end else begin
            r_ovalid <= 1'b0;
            if (weight_en) begin
                r_w   <= {weight, r_w[N_W-1:1]};
                r_cnt <= '0;
                r_acc <= '0;
            end else if (ivalid) begin
                if (r_cnt == CNT_W'(N_BEATS - 1)) begin
                    r_dout   <= w_sum;
                    r_ovalid <= 1'b1;
                    r_acc    <= '0;
                    r_cnt    <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign ovalid = r_ovalid;
    assign dout   = r_dout;

endmodule

// File: tb/tb_fc_12.sv
// Self-checking bench for fc_12: directed plan plus randomized traffic against a dot-product model.
module tb_fc_12;
    import fc_12_pkg::*;

    logic                 clk;
    logic                 rstn;
    logic                 ivalid;
    logic                 weight;
    logic                 weight_en;
    logic signed [DW-1:0] din [N_LANES];
    logic                 ovalid;
    logic signed [DW-1:0] dout;

    int n_tests;
    int n_fail;

    // Reference model: list of loaded weight bits (last 192 are live) and the inputs of the open frame.
    bit          wq[$];
    longint      fx[N_W];
    int          nb;
    logic        exp_ovalid;
    logic [31:0] exp_dout;

    fc_12 dut (
        .clk       (clk),
        .rstn      (rstn),
        .ivalid    (ivalid),
        .din_0     (din[0]),
        .din_1     (din[1]),
        .din_2     (din[2]),
        .din_3     (din[3]),
        .din_4     (din[4]),
        .din_5     (din[5]),
        .din_6     (din[6]),
        .din_7     (din[7]),
        .din_8     (din[8]),
        .din_9     (din[9]),
        .din_10    (din[10]),
        .din_11    (din[11]),
        .weight    (weight),
        .weight_en (weight_en),
        .ovalid    (ovalid),
        .dout      (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)", tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    function automatic logic [31:0] model_dot();
        longint s = 0;
        int base = wq.size() - N_W;
        for (int i = 0; i < N_W; i++) begin
            s += wq[base + i] ? fx[i] : -fx[i];
        end
        return s[31:0];
    endfunction

    task automatic model_reset();
        wq.delete();
        for (int i = 0; i < N_W; i++) wq.push_back(1'b0);
        nb         = 0;
        exp_ovalid = 1'b0;
        exp_dout   = '0;
    endtask

    // Apply current inputs for one clock edge, advance the model, compare outputs after the edge.
    task automatic cycle(input string tag);
        exp_ovalid = 1'b0;
        if (weight_en) begin
            wq.push_back(weight);
            if (wq.size() > N_W) void'(wq.pop_front());
            nb = 0;
        end else if (ivalid) begin
            for (int j = 0; j < N_LANES; j++) fx[nb * N_LANES + j] = longint'(din[j]);
            nb++;
            if (nb == N_BEATS) begin
                exp_dout   = model_dot();
                exp_ovalid = 1'b1;
                nb         = 0;
            end
        end
        @(posedge clk);
        #1;
        check({tag, ".ovalid"}, {31'd0, ovalid}, {31'd0, exp_ovalid});
        check({tag, ".dout"}, dout, exp_dout);
    endtask

    task automatic load_bit(input bit b, input string tag);
        weight_en = 1'b1;
        weight    = b;
        ivalid    = 1'($urandom);
        for (int j = 0; j < N_LANES; j++) din[j] = $urandom;
        cycle(tag);
        weight_en = 1'b0;
        ivalid    = 1'b0;
    endtask

    task automatic load_const(input bit b, input string tag);
        for (int i = 0; i < N_W; i++) load_bit(b, tag);
    endtask

    task automatic beat_const(input int v, input string tag);
        ivalid = 1'b1;
        for (int j = 0; j < N_LANES; j++) din[j] = v;
        cycle(tag);
        ivalid = 1'b0;
    endtask

    task automatic idle(input string tag);
        ivalid    = 1'b0;
        weight_en = 1'b0;
        cycle(tag);
    endtask

    task automatic do_reset(input string tag);
        rstn = 1'b0;
        model_reset();
        #1;
        check({tag, ".rst_ovalid"}, {31'd0, ovalid}, 32'd0);
        check({tag, ".rst_dout"}, dout, 32'd0);
        @(posedge clk);
        #1;
        check({tag, ".rst_ovalid_hold"}, {31'd0, ovalid}, 32'd0);
        check({tag, ".rst_dout_hold"}, dout, 32'd0);
        rstn = 1'b1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rstn      = 1'b0;
        ivalid    = 1'b0;
        weight    = 1'b0;
        weight_en = 1'b0;
        for (int j = 0; j < N_LANES; j++) din[j] = '0;
        @(posedge clk);
        #1;
        do_reset("init");

        // All +1 weights, din=1 -> 192.
        load_const(1'b1, "ones_load");
        repeat (N_BEATS) beat_const(1, "ones");
        check("ones.expect", exp_dout, 32'd192);
        idle("ones_hold");

        // All -1 weights, din=1 -> -192.
        load_const(1'b0, "zeros_load");
        repeat (N_BEATS) beat_const(1, "zeros");
        check("zeros.expect", exp_dout, -32'sd192);
        idle("zeros_hold");

        // Alternating weights, din_j=j+1 -> -96.
        for (int i = 0; i < N_W; i++) load_bit(bit'(i % 2 == 0), "alt_load");
        for (int k = 0; k < N_BEATS; k++) begin
            ivalid = 1'b1;
            for (int j = 0; j < N_LANES; j++) din[j] = j + 1;
            cycle("alt");
        end
        ivalid = 1'b0;
        check("alt.expect", exp_dout, -32'sd96);
        idle("alt_hold");

        // Back-to-back frames with no bubble.
        load_const(1'b1, "b2b_load");
        repeat (N_BEATS) beat_const(1, "b2b_f1");
        check("b2b.first", exp_dout, 32'd192);
        repeat (N_BEATS) beat_const(2, "b2b_f2");
        check("b2b.second", exp_dout, 32'd384);
        idle("b2b_hold");

        // Gap of three idle cycles in the middle of a frame.
        repeat (8) beat_const(5, "gap_a");
        repeat (3) idle("gap_idle");
        repeat (8) beat_const(5, "gap_b");
        check("gap.expect", exp_dout, 32'd960);
        repeat (2) idle("gap_hold");

        // weight_en mid-frame discards the partial frame.
        repeat (7) beat_const(3, "wen_partial");
        load_bit(1'b1, "wen_mid");
        repeat (N_BEATS) beat_const(1, "wen_frame");
        check("wen.expect", exp_dout, 32'd192);

        // Reset mid-frame, reload, full frame.
        repeat (5) beat_const(1, "mid_partial");
        do_reset("mid");
        load_const(1'b1, "mid_load");
        repeat (N_BEATS) beat_const(1, "mid_frame");
        check("mid.expect", exp_dout, 32'd192);
        idle("mid_hold");

        // Over-long load (last 192 kept), then randomized traffic with full-range data.
        for (int i = 0; i < N_W + 37; i++) load_bit(1'($urandom), "rnd_load");
        for (int c = 0; c < 900; c++) begin
            int r = int'($urandom_range(0, 199));
            if (r < 1) begin
                load_bit(1'($urandom), "rnd_wen");
            end else if (r < 150) begin
                ivalid = 1'b1;
                for (int j = 0; j < N_LANES; j++) din[j] = $urandom;
                cycle("rnd_beat");
                ivalid = 1'b0;
            end else begin
                idle("rnd_idle");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fc_12.md
Name: fc_12

Overview:
- Binary-weight fully-connected neuron for the BNN-on-FPGA datapath.
- Computes one signed 32-bit dot product over 192 inputs. Inputs arrive as 12 parallel lanes per beat, 16 beats per frame.
- Each weight is 1 bit: 1 means +1, 0 means -1. Weights are loaded serially, one bit per clock, before inference.
- Sits after the last conv/pool stage and feeds the classifier output.

Parameters:
- N_LANES, 12, number of parallel input lanes (din_0..din_11).
- N_BEATS, 16, beats per frame; N_W = N_LANES*N_BEATS = 192 weights.
- DW, 32, input, accumulator and output width (signed two's complement).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- ivalid  in  1  the 12 din lanes carry a valid beat this cycle.
- din_0 .. din_11  in  32 each  signed input lanes; lane j of beat k is input index k*12+j.
- weight  in  1  serial weight bit (1 = +1, 0 = -1).
- weight_en  in  1  the weight bit is valid this cycle.
- ovalid  out  1  single-cycle pulse: dout holds a new result.
- dout  out  32  signed dot-product result.

Behaviour:
- Reset (asynchronous, rstn=0):
  - ovalid=0, dout=0.
  - Beat counter=0, accumulator=0, weight register=all 0.
- Weight load:
  - 192-bit shift register. Each cycle with weight_en=1, the new bit enters at index 191 and the register shifts down.
  - After exactly 192 loads, the first-loaded bit sits at index 0.
  - More than 192 loads: the oldest bits are discarded; the last 192 loaded are kept.
- weight_en priority:
  - weight_en=1 has priority over ivalid; ivalid is ignored that cycle.
  - Beat counter and accumulator are cleared while weight_en=1.
- Beat processing (ivalid=1, weight_en=0):
  - partial = sum over j of (w[k*12+j] ? +din_j : -din_j), where k = beat counter.
  - Computed combinationally, all arithmetic 32-bit signed with wrap-around (no saturation).
  - Beats 0..14: acc <= acc + partial; counter increments.
  - Beat 15: dout <= acc + partial; ovalid <= 1; acc <= 0; counter <= 0.
  - Latency: result valid on the cycle after the 16th valid beat.
- ivalid=0: counter and accumulator hold. Gaps between beats are allowed; beats need not be contiguous.
- ovalid is high for exactly one cycle per completed frame; otherwise 0.
- dout holds its value until the next frame completes.
- Back-to-back frames: beat 0 of the next frame may occur in the cycle right after beat 15, with no bubble.
- Weights persist across frames until reloaded or reset.
- Reset mid-frame: the partial frame is discarded; the counter restarts at 0 after release.

Decomposition:
- Shared BNN package: N_LANES, N_BEATS, DW, and a helper function for binary-signed multiply (sel ? x : -x).
- One natural sub-module: fc_lane_sum. It takes 12 lanes plus a 12-bit weight slice and produces the signed partial sum.
- Weight register, beat counter and accumulator stay in fc_12.

Test Plan:
- Load 192 ones; 16 beats with every din=1 -> one ovalid pulse, dout=192, on the cycle after beat 15.
- Load 192 zeros; 16 beats with every din=1 -> dout=-192.
- Load alternating weights (even index=1, odd=0); din_j=j+1 on every beat -> per-beat partial=-6, dout=-96.
- Weights all ones; two back-to-back frames, first with din=1, second with din=2 -> ovalid at cycles 17 and 33 after the first beat, dout=192 then 384.
- Weights all ones; 8 beats of din=5, ivalid low 3 cycles, 8 more beats -> dout=960, exactly one ovalid pulse.
- Mid-frame rstn pulse after 5 beats, then 16 beats of din=1 with weights all ones reloaded -> dout=192; ovalid=0 and dout=0 during reset.
